fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that generates the fetch PC, issues instruction-memory reads, and buffers returned instructions in a 2-entry queue. It feeds the IF/ID pipeline register with instruction, PC and next-PC. It absorbs variable memory latency and decode-side stalls. It flushes on branch/jump redirects from later stages.

## Interface
- `RESET_PC`, default `32'h0000_3000`: fetch PC loaded on reset.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: ID cannot accept; the head entry is held.
- `redirect` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch address; bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: single-cycle pulse issuing a read of `imem_addr`.
- `imem_addr` out 32: word-aligned read address, valid while `imem_req` is high.
- `imem_ack` in 1: read data valid; arrives 1 or more cycles after `imem_req`.
- `imem_rdata` in 32: instruction word, valid while `imem_ack` is high.
- `if_valid` out 1: the output triple is valid; consumed when `if_valid & ~stall & ~redirect`.
- `if_inst` out 32: instruction.
- `if_pc` out 32: PC of `if_inst`.
- `if_npc` out 32: `if_pc + 4`, modulo 2^32.

## Operation
- **State:**
  - fetch PC `fpc`;
  - 2-entry queue of {pc, inst} with 2-bit `count`;
  - request FSM with states IDLE, WAIT, DROP.
- **At most one request is outstanding.** A request is issued when all of the following hold:
  - the state is IDLE, or WAIT with `imem_ack` this cycle;
  - no `redirect` this cycle;
  - free slots after this cycle's pop and ack are at least 1.
- **On issue:** `imem_addr = fpc`, `fpc <= fpc + 4` (wraps from `32'hFFFF_FFFC` to 0), next state is WAIT.
- **FSM transitions:**
  - IDLE → WAIT on issue.
  - WAIT with ack: push {request pc, `imem_rdata`}, then go to WAIT if reissuing, otherwise IDLE.
  - WAIT with `redirect` and no ack: go to DROP.
  - DROP with ack: discard the data, go to IDLE. Fetching from the redirect target resumes the next cycle.
- **Pop:** occurs when `if_valid & ~stall & ~redirect`.
- **Redirect** (dominates `stall`, pop and push):
  - queue cleared, `count <= 0`;
  - `fpc <= {redirect_pc[31:2], 2'b00}`;
  - any ack in the same cycle is discarded;
  - no request issued that cycle.
- **Memory order:** responses are assumed in order; the pc of the outstanding request is held in a register.
- **Ack when idle:** `imem_ack` in IDLE (e.g. a stale response after reset) is ignored.
- **Simultaneous push and pop** with `count = 2` cannot occur, because issue is gated on free space.
- **Queue empty:** `if_valid = 0`, `if_inst = 0` (NOP), `if_pc` = 0, `if_npc` = 4.

## Timing
- **Reset values:**
  - `fpc = RESET_PC`;
  - `count = 0`;
  - state IDLE;
  - `imem_req = 0`;
  - `if_valid = 0`, `if_inst = 0`, `if_pc = 0`, `if_npc = 4`.
- **First request:** issued in the first cycle after `rst` deasserts.
- **Fetch latency:** with a 1-cycle memory (ack in the cycle after req), `if_valid` rises 2 cycles after the request. The data is registered into the queue on the ack edge.
- **Throughput:** sustained 1 instruction/cycle with a 1-cycle memory and no stall.
- **Stall:** outputs hold stable; fetch continues until the queue fills.
- **Redirect:** `if_valid = 0` in the cycle after redirect. The target request issues in that cycle if the state is IDLE, otherwise after the DROP ack.
- **Reset mid-operation:** immediate return to the reset values; the in-flight response is ignored.

## Configuration
- **`FETCH_BYPASS_EN` defined:**
  - when the queue is empty (or about to be empty) and a live ack arrives, the response drives the outputs combinationally in the ack cycle;
  - if it is popped that cycle, it is not written into the queue;
  - first-instruction latency becomes 1 cycle after the request.
- **`FETCH_BYPASS_EN` undefined:** outputs come only from the queue head.

## Test plan
- **Reset and first fetch:** 1-cycle memory, `rst` high 3 cycles then low → `imem_addr = 0x3000` in the first cycle after release; `if_valid` 2 cycles later with `if_pc = 0x3000`, `if_npc = 0x3004`. With `FETCH_BYPASS_EN`, the same values appear 1 cycle earlier.
- **Streaming:** 1-cycle memory, no stall → consecutive `if_pc` values 0x3000, 0x3004, 0x3008 … one per cycle.
- **Stall:**
  - `stall` held for 4 cycles → outputs constant;
  - `count` saturates at 2 and `imem_req` stays low;
  - on release, the buffered PCs emerge in order with no gap or duplicate.
- **Redirect with a request outstanding:** 3-cycle memory; `redirect = 1`, `redirect_pc = 0x4006` while in WAIT → the stale response is dropped, the next `imem_addr = 0x4004`, and the first valid `if_pc = 0x4004`.
- **Redirect colliding with ack and stall:** ack, `stall` and `redirect` in the same cycle → queue empty next cycle and the acked data never appears.
- **Wrap and late ack:**
  - `redirect_pc = 0xFFFF_FFFC` → the following fetch address is 0x0000_0000, and `if_npc` for that instruction is 0x0000_0000;
  - a spurious `imem_ack` while IDLE has no effect.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC generation, single-outstanding imem reads and a 2-entry {pc,inst} queue feeding IF/ID.
// Optional FETCH_BYPASS_EN: a live ack into an empty queue drives the outputs in the ack cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [31:0] fpc, req_pc;
  logic [31:0] q_pc [2];
  logic [31:0] q_inst [2];
  logic [1:0] count, count_nx;
  logic live_ack, bypass, pop, push, issue, wr_idx;
  assign live_ack = imem_ack & (state == WAIT) & ~redirect;
`ifdef FETCH_BYPASS_EN
  assign bypass = (count == 2'd0) & imem_ack & (state == WAIT);
`else
  assign bypass = 1'b0;
`endif
  assign if_valid = (count != 2'd0) | bypass;
  assign if_pc = bypass ? req_pc : (count != 2'd0) ? q_pc[0] : 32'd0;
  assign if_inst = bypass ? imem_rdata : (count != 2'd0) ? q_inst[0] : 32'd0;
  assign if_npc = if_pc + 32'd4;
  assign pop = if_valid & ~stall & ~redirect;
  // a bypassed response that is consumed in the same cycle never enters the queue
  assign push = live_ack & ~(bypass & pop);
  assign count_nx = count + {1'b0, push} - {1'b0, pop};
  assign wr_idx = count[0] ^ pop;
  assign issue = ~rst & ~redirect & ((state == IDLE) | ((state == WAIT) & imem_ack)) & (count_nx != 2'd2);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = issue ? WAIT : IDLE;
      WAIT:    state_nx = imem_ack ? (issue ? WAIT : IDLE) : redirect ? DROP : WAIT;
      DROP:    state_nx = imem_ack ? IDLE : DROP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    imem_req = issue;
    imem_addr = issue ? fpc : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc <= RESET_PC;
      req_pc <= 32'd0;
      count <= 2'd0;
    end else begin
      fpc <= redirect ? (redirect_pc & 32'hFFFF_FFFC) : issue ? fpc + 32'd4 : fpc;
      if (issue) req_pc <= fpc;
      count <= redirect ? 2'd0 : count_nx;
      if (pop) begin
        q_pc[0] <= q_pc[1];
        q_inst[0] <= q_inst[1];
      end
      if (push) begin
        q_pc[wr_idx] <= req_pc;
        q_inst[wr_idx] <= imem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a program-order reference model.
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic if_valid;
  logic [31:0] if_inst, if_pc, if_npc;
  int n_vec = 0, n_err = 0;
  bit mem_busy = 1'b0, spurious = 1'b0;
  int mem_cnt = 0, lat_min = 1, lat_max = 1;
  logic [31:0] mem_addr = 32'd0, exp_pc, exp_addr;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_npc(if_npc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // memory answers its single request after a latency drawn at request time
  task automatic settle();
    imem_ack = (mem_busy && mem_cnt == 1) || (!mem_busy && spurious);
    imem_rdata = mem_busy ? word_at(mem_addr) : 32'hBAD0_BAD0;
    #1;
  endtask

  task automatic clock_edge();
    if (rst) mem_busy = 1'b0;
    else begin
      if (mem_busy) begin
        if (mem_cnt == 1) mem_busy = 1'b0;
        else mem_cnt--;
      end
      if (imem_req) begin
        mem_busy = 1'b1;
        mem_cnt = $urandom_range(lat_max, lat_min);
        mem_addr = imem_addr;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int lmin, input int lmax);
    lat_min = lmin;
    lat_max = lmax;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; spurious = 1'b0;
    repeat (3) begin settle(); clock_edge(); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin settle(); clock_edge(); end
    settle();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    n_vec++; if (if_inst !== 32'd0) begin n_err++; $display("FAIL reset_inst: got %h expected 0", if_inst); end
    n_vec++; if (if_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
    n_vec++; if (if_npc !== 32'd4) begin n_err++; $display("FAIL reset_npc: got %h expected 4", if_npc); end
    clock_edge();
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    logic [31:0] a;
    do_reset(1, 1);
    a = 32'h3000;
    for (int c = 0; c <= FIRST_LAT; c++) begin
      settle();
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_err++; $display("FAIL first_req c%0d: got req=%b addr=%h expected req=1 addr=%h", c, imem_req, imem_addr, a); end
      n_vec++; if (if_valid !== (c == FIRST_LAT)) begin n_err++; $display("FAIL first_valid c%0d: got %b expected %b", c, if_valid, c == FIRST_LAT); end
      if (c == FIRST_LAT) begin
        n_vec++; if (if_pc !== 32'h3000 || if_npc !== 32'h3004 || if_inst !== word_at(32'h3000)) begin n_err++; $display("FAIL first_out: got pc=%h npc=%h inst=%h expected pc=00003000 npc=00003004 inst=%h", if_pc, if_npc, if_inst, word_at(32'h3000)); end
      end
      a += 32'd4;
      clock_edge();
    end
    exp_pc = 32'h3004;
    exp_addr = a;
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 10; k++) begin
      settle();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_npc !== exp_pc + 32'd4 || if_inst !== word_at(exp_pc)) begin n_err++; $display("FAIL stream_out k%0d: got v=%b pc=%h npc=%h inst=%h expected pc=%h", k, if_valid, if_pc, if_npc, if_inst, exp_pc); end
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_err++; $display("FAIL stream_req k%0d: got req=%b addr=%h expected addr=%h", k, imem_req, imem_addr, exp_addr); end
      exp_pc += 32'd4;
      exp_addr += 32'd4;
      clock_edge();
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== word_at(exp_pc)) begin n_err++; $display("FAIL stall_hold k%0d: got v=%b pc=%h expected pc=%h", k, if_valid, if_pc, exp_pc); end
      if (k >= 2) begin
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req k%0d: got %b expected 0", k, imem_req); end
      end
      clock_edge();
    end
    stall = 1'b0;
    exp_addr = exp_pc + 32'd8;
    for (int k = 0; k < 6; k++) begin
      settle();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== word_at(exp_pc)) begin n_err++; $display("FAIL stall_release k%0d: got v=%b pc=%h expected pc=%h", k, if_valid, if_pc, exp_pc); end
      if (imem_req) begin
        n_vec++; if (imem_addr !== exp_addr) begin n_err++; $display("FAIL stall_release_addr k%0d: got %h expected %h", k, imem_addr, exp_addr); end
        exp_addr += 32'd4;
      end
      exp_pc += 32'd4;
      clock_edge();
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    do_reset(3, 3);
    settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_err++; $display("FAIL rw_req0: got req=%b addr=%h expected 1/00003000", imem_req, imem_addr); end
    clock_edge();
    redirect = 1'b1; redirect_pc = 32'h4006;
    settle();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rw_req_redirect: got %b expected 0", imem_req); end
    clock_edge();
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_vec++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL rw_drop k%0d: got v=%b req=%b expected 0/0", k, if_valid, imem_req); end
      clock_edge();
    end
    settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h4004) begin n_err++; $display("FAIL rw_target_req: got req=%b addr=%h expected 1/00004004", imem_req, imem_addr); end
    clock_edge();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      settle();
      if (if_valid) begin
        found = 1'b1;
        n_vec++; if (if_pc !== 32'h4004 || if_npc !== 32'h4008 || if_inst !== word_at(32'h4004)) begin n_err++; $display("FAIL rw_first: got pc=%h npc=%h inst=%h expected pc=00004004", if_pc, if_npc, if_inst); end
      end
      clock_edge();
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rw_timeout: got no valid expected pc=00004004"); end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] e;
    int seen;
    do_reset(1, 1);
    repeat (FIRST_LAT + 3) begin settle(); clock_edge(); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h5000;
    settle();
    clock_edge();
    stall = 1'b0; redirect = 1'b0;
    settle();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rc_empty: got %b expected 0", if_valid); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin n_err++; $display("FAIL rc_req: got req=%b addr=%h expected 1/00005000", imem_req, imem_addr); end
    clock_edge();
    e = 32'h5000;
    seen = 0;
    for (int k = 0; k < 12 && seen < 3; k++) begin
      settle();
      if (if_valid) begin
        n_vec++; if (if_pc !== e || if_inst !== word_at(e)) begin n_err++; $display("FAIL rc_seq: got pc=%h inst=%h expected pc=%h", if_pc, if_inst, e); end
        e += 32'd4;
        seen++;
      end
      clock_edge();
    end
    n_vec++; if (seen != 3) begin n_err++; $display("FAIL rc_timeout: got %0d outputs expected 3", seen); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    int seen;
    do_reset(1, 1);
    repeat (3) begin settle(); clock_edge(); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    settle();
    clock_edge();
    redirect = 1'b0;
    settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req0: got req=%b addr=%h expected 1/fffffffc", imem_req, imem_addr); end
    clock_edge();
    settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_req1: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    clock_edge();
    e = 32'hFFFF_FFFC;
    seen = 0;
    for (int k = 0; k < 8 && seen < 2; k++) begin
      settle();
      if (if_valid) begin
        n_vec++; if (if_pc !== e || if_npc !== e + 32'd4 || if_inst !== word_at(e)) begin n_err++; $display("FAIL wrap_out: got pc=%h npc=%h expected pc=%h npc=%h", if_pc, if_npc, e, e + 32'd4); end
        e += 32'd4;
        seen++;
      end
      clock_edge();
    end
    n_vec++; if (seen != 2) begin n_err++; $display("FAIL wrap_timeout: got %0d outputs expected 2", seen); end
    stall = 1'b1;
    repeat (4) begin settle(); clock_edge(); end
    spurious = 1'b1;
    settle();
    n_vec++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== e) begin n_err++; $display("FAIL spurious_cycle: got req=%b v=%b pc=%h expected 0/1/%h", imem_req, if_valid, if_pc, e); end
    clock_edge();
    spurious = 1'b0; stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== e || if_inst !== word_at(e)) begin n_err++; $display("FAIL spurious_after k%0d: got v=%b pc=%h inst=%h expected pc=%h", k, if_valid, if_pc, if_inst, e); end
      e += 32'd4;
      clock_edge();
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_fetch, e;
    bit prev_hold, prev_clear;
    int idle_run;
    do_reset(1, 4);
    exp_fetch = 32'h3000; e = 32'h3000;
    prev_hold = 1'b0; prev_clear = 1'b0; idle_run = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      redirect = ($urandom_range(24) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      stall = ($urandom_range(2) == 0);
      spurious = ($urandom_range(19) == 0);
      settle();
      if (imem_req) begin
        n_vec++; if (rst || (mem_busy && !imem_ack) || imem_addr !== exp_fetch) begin n_err++; $display("FAIL rnd_req i%0d: got addr=%h rst=%b busy=%b expected addr=%h", i, imem_addr, rst, mem_busy, exp_fetch); end
      end
      if (if_valid) begin
        n_vec++; if (if_pc !== e || if_npc !== e + 32'd4 || if_inst !== word_at(e)) begin n_err++; $display("FAIL rnd_out i%0d: got pc=%h npc=%h inst=%h expected pc=%h", i, if_pc, if_npc, if_inst, e); end
      end
      if (prev_hold || prev_clear) begin
        n_vec++; if (if_valid !== prev_hold) begin n_err++; $display("FAIL rnd_hold i%0d: got v=%b expected %b", i, if_valid, prev_hold); end
      end
      if (rst || redirect || if_valid) idle_run = 0;
      else if (!stall) begin
        idle_run++;
        n_vec++; if (idle_run > 14) begin n_err++; $display("FAIL rnd_starve i%0d: got %0d idle cycles expected <= 14", i, idle_run); idle_run = 0; end
      end
      prev_hold = if_valid && stall && !redirect && !rst;
      prev_clear = redirect || rst;
      if (rst) begin
        exp_fetch = 32'h3000; e = 32'h3000;
      end else if (redirect) begin
        exp_fetch = redirect_pc & 32'hFFFF_FFFC; e = exp_fetch;
      end else begin
        if (imem_req) exp_fetch += 32'd4;
        if (if_valid && !stall) e += 32'd4;
      end
      clock_edge();
    end
    rst = 1'b0; redirect = 1'b0; stall = 1'b0; spurious = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_streaming();
    test_stall();
    test_redirect_wait();
    test_redirect_collide();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end
endmodule
